// File: rtl/klotski_pkg.sv
// Shared definitions for the Klotski board overlay: VGA/grid constants,
// overlay FSM state type and the tile colour palette.
package klotski_pkg;

    // VGA timing / placement constants used across the camera pipeline
    localparam int unsigned X_START     = 35;
    localparam int unsigned Y_START     = 36;
    localparam int unsigned START_H_POS = 120;
    localparam int unsigned START_V_POS = 10;

    // Grid geometry
    localparam int unsigned GRID_N    = 4;
    localparam int unsigned TILE_BITS = 4;
    localparam int unsigned CNT_W     = 13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    // Tile id 0 is "empty" and shows the camera pixel, so it has no entry
    localparam logic [23:0] PALETTE [1:15] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF00FF,
        24'h00FFFF, 24'hFF8000, 24'h8000FF, 24'h0080FF, 24'h80FF00,
        24'hFF0080, 24'h00FF80, 24'h808080, 24'h804000, 24'h400080
    };

    function automatic logic [23:0] palette_color(input logic [3:0] id);
        return (id == 4'd0) ? 24'h000000 : PALETTE[id];
    endfunction

endpackage

// File: rtl/klotski_cell_locator.sv
// Maps a raw H/V counter pair onto the 4x4 Klotski grid: cell row/column,
// whether the point is inside the grid, and whether it sits on a cell edge.
module klotski_cell_locator
    import klotski_pkg::*;
#(
    parameter int unsigned LEFT_ORIGIN = 155,
    parameter int unsigned UP_ORIGIN   = 46,
    parameter int unsigned CELL_W      = 140,
    parameter int unsigned CELL_H      = 136,
    parameter int unsigned BORDER      = 2
) (
    input  logic [CNT_W-1:0] h_count,
    input  logic [CNT_W-1:0] v_count,
    output logic             in_grid,
    output logic             on_border,
    output logic [1:0]       row,
    output logic [1:0]       col
);

    localparam logic [CNT_W-1:0] H_LO = CNT_W'(LEFT_ORIGIN);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(LEFT_ORIGIN + GRID_N * CELL_W);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(UP_ORIGIN);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(UP_ORIGIN + GRID_N * CELL_H);

    logic [CNT_W-1:0] h_edge;
    logic [CNT_W-1:0] v_edge;
    logic [CNT_W-1:0] h_off;
    logic [CNT_W-1:0] v_off;
    int unsigned      h_bound;
    int unsigned      v_bound;

    // Step the row/column index past every cell edge already reached; the
    // bounds are elaboration-time constants so only comparators are built.
    always_comb begin
        col     = '0;
        row     = '0;
        h_edge  = H_LO;
        v_edge  = V_LO;
        h_bound = LEFT_ORIGIN;
        v_bound = UP_ORIGIN;
        for (int unsigned k = 1; k < GRID_N; k++) begin
            h_bound = h_bound + CELL_W;
            v_bound = v_bound + CELL_H;
            if (h_count >= CNT_W'(h_bound)) begin
                col    = 2'(k);
                h_edge = CNT_W'(h_bound);
            end
            if (v_count >= CNT_W'(v_bound)) begin
                row    = 2'(k);
                v_edge = CNT_W'(v_bound);
            end
        end
        h_off     = h_count - h_edge;
        v_off     = v_count - v_edge;
        in_grid   = (h_count >= H_LO) && (h_count < H_HI) &&
                    (v_count >= V_LO) && (v_count < V_HI);
        on_border = (h_off < CNT_W'(BORDER)) || (h_off >= CNT_W'(CELL_W - BORDER)) ||
                    (v_off < CNT_W'(BORDER)) || (v_off >= CNT_W'(CELL_H - BORDER));
    end

endmodule

// File: rtl/klotski_board_overlay.sv
// Overlays the Klotski board onto the camera stream. Boards are offered
// through a one-deep shadow register and committed at frame start; the
// pixel path is a fixed two-stage pipeline in every state.
module klotski_board_overlay
    import klotski_pkg::*;
#(
    parameter int unsigned LEFT_ORIGIN = 155,
    parameter int unsigned UP_ORIGIN   = 46,
    parameter int unsigned CELL_W      = 140,
    parameter int unsigned CELL_H      = 136,
    parameter int unsigned BORDER      = 2
) (
    input  logic              i_Clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [7:0]        i_Red,
    input  logic [7:0]        i_Green,
    input  logic [7:0]        i_Blue,
    input  logic [CNT_W-1:0]  i_H_Counter,
    input  logic [CNT_W-1:0]  i_V_Counter,
    input  logic [63:0]       i_board,
    input  logic              i_board_valid,
    output logic              o_board_ready,
    output logic [7:0]        o_Red,
    output logic [7:0]        o_Green,
    output logic [7:0]        o_Blue,
    output logic              o_frame_done
);

    localparam logic [CNT_W-1:0] LAST_H = CNT_W'(LEFT_ORIGIN + GRID_N * CELL_W - 1);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(UP_ORIGIN + GRID_N * CELL_H - 1);

    state_t           state;
    logic [63:0]      shadow_board;
    logic [63:0]      active_board;
    logic             shadow_full;

    logic             p1_vld;
    logic [7:0]       p1_red;
    logic [7:0]       p1_green;
    logic [7:0]       p1_blue;
    logic [CNT_W-1:0] p1_h;
    logic [CNT_W-1:0] p1_v;

    logic             frame_flag;
    logic             last_px2;

    logic             frame_start;
    logic             board_accept;
    logic             last_hit;
    logic             in_grid;
    logic             on_border;
    logic [1:0]       row;
    logic [1:0]       col;
    logic [5:0]       tile_lsb;
    logic [3:0]       tile_id;
    logic [23:0]      cam_rgb;
    logic [23:0]      draw_rgb;

    assign o_board_ready = !shadow_full;
    assign board_accept  = i_board_valid && !shadow_full;
    assign frame_start   = p1_vld && (p1_h == '0) && (p1_v == '0);
    assign cam_rgb       = {p1_red, p1_green, p1_blue};
    assign tile_lsb      = 6'd60 - {row, col, 2'b00};
    assign tile_id       = active_board[tile_lsb +: TILE_BITS];
    assign last_hit      = (state == S_DRAW) && (p1_h == LAST_H) &&
                           (p1_v == LAST_V) && !frame_flag;

    klotski_cell_locator #(
        .LEFT_ORIGIN (LEFT_ORIGIN),
        .UP_ORIGIN   (UP_ORIGIN),
        .CELL_W      (CELL_W),
        .CELL_H      (CELL_H),
        .BORDER      (BORDER)
    ) u_locator (
        .h_count   (p1_h),
        .v_count   (p1_v),
        .in_grid   (in_grid),
        .on_border (on_border),
        .row       (row),
        .col       (col)
    );

    // Stage 1: register camera pixel and raw counters
    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            p1_vld   <= 1'b0;
            p1_red   <= '0;
            p1_green <= '0;
            p1_blue  <= '0;
            p1_h     <= '0;
            p1_v     <= '0;
        end else begin
            p1_vld   <= 1'b1;
            p1_red   <= i_Red;
            p1_green <= i_Green;
            p1_blue  <= i_Blue;
            p1_h     <= i_H_Counter;
            p1_v     <= i_V_Counter;
        end
    end

    // Shadow/active board handoff; a full shadow blocks accepts, so a commit
    // and an accept never compete for the shadow in the same cycle
    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            shadow_board <= '0;
            active_board <= '0;
            shadow_full  <= 1'b0;
        end else if (frame_start && shadow_full) begin
            active_board <= shadow_board;
            shadow_full  <= 1'b0;
        end else if (board_accept) begin
            shadow_board <= i_board;
            shadow_full  <= 1'b1;
        end
    end

    // Overlay mode: arm on enable, draw from the next frame start, drop on disable
    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (i_enable) state <= S_ARMED;
                S_ARMED: if (!i_enable) state <= S_IDLE;
                         else if (frame_start) state <= S_DRAW;
                S_DRAW:  if (!i_enable) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage 2 colour select: grid lines, tile colour or camera pass-through
    always_comb begin
        draw_rgb = cam_rgb;
        if ((state == S_DRAW) && in_grid) begin
            if (on_border) begin
                draw_rgb = 24'hFFFFFF;
            end else if (tile_id != 4'd0) begin
                draw_rgb = palette_color(tile_id);
            end
        end
    end

    // Stage 2 registers plus the delayed, once-per-frame completion pulse
    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            o_Red        <= '0;
            o_Green      <= '0;
            o_Blue       <= '0;
            last_px2     <= 1'b0;
            o_frame_done <= 1'b0;
            frame_flag   <= 1'b0;
        end else begin
            {o_Red, o_Green, o_Blue} <= draw_rgb;
            last_px2     <= last_hit;
            o_frame_done <= last_px2;
            if (frame_start) begin
                frame_flag <= 1'b0;
            end else if (last_hit) begin
                frame_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_klotski_board_overlay.sv
// Randomised directed bench for klotski_board_overlay with a pixel-level
// reference model built from grid arithmetic (division/modulo).
module tb_klotski_board_overlay;

    localparam int LEFT   = 155;
    localparam int UP     = 46;
    localparam int CW     = 140;
    localparam int CH     = 136;
    localparam int BRD    = 2;
    localparam int LAST_H = LEFT + 4 * CW - 1;
    localparam int LAST_V = UP + 4 * CH - 1;

    logic        clk;
    logic        i_rst;
    logic        i_enable;
    logic [7:0]  i_Red, i_Green, i_Blue;
    logic [12:0] i_H_Counter, i_V_Counter;
    logic [63:0] i_board;
    logic        i_board_valid;
    logic        o_board_ready;
    logic [7:0]  o_Red, o_Green, o_Blue;
    logic        o_frame_done;

    klotski_board_overlay #(
        .LEFT_ORIGIN (LEFT),
        .UP_ORIGIN   (UP),
        .CELL_W      (CW),
        .CELL_H      (CH),
        .BORDER      (BRD)
    ) dut (
        .i_Clk         (clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_Red         (i_Red),
        .i_Green       (i_Green),
        .i_Blue        (i_Blue),
        .i_H_Counter   (i_H_Counter),
        .i_V_Counter   (i_V_Counter),
        .i_board       (i_board),
        .i_board_valid (i_board_valid),
        .o_board_ready (o_board_ready),
        .o_Red         (o_Red),
        .o_Green       (o_Green),
        .o_Blue        (o_Blue),
        .o_frame_done  (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] rgb;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    // Driver intent
    bit          en;
    bit          bval;
    logic [63:0] bdat;

    // Reference model state
    bit          m_armed, m_drawing, m_full, m_acc, m_prev_zero, m_done_sent, m_hit_prev;
    logic [63:0] m_shadow, m_active;

    function automatic logic [23:0] ref_color(input int h, input int v, input logic [23:0] cam,
                                              input bit drawing, input logic [63:0] board);
        int r, c, ox, oy;
        logic [3:0] id;
        if (!drawing) return cam;
        if (h < LEFT || h >= LEFT + 4 * CW || v < UP || v >= UP + 4 * CH) return cam;
        c  = (h - LEFT) / CW;
        ox = (h - LEFT) % CW;
        r  = (v - UP) / CH;
        oy = (v - UP) % CH;
        if (ox < BRD || ox >= CW - BRD || oy < BRD || oy >= CH - BRD) return 24'hFFFFFF;
        id = 4'(board >> (60 - 4 * (4 * r + c)));
        if (id == 4'd0) return cam;
        if (id == 4'd1) return 24'hFF0000;
        if (id == 4'd2) return 24'h00FF00;
        return klotski_pkg::PALETTE[id];
    endfunction

    task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_drawing = 0; m_full = 0; m_acc = 0;
        m_prev_zero = 0; m_done_sent = 0; m_hit_prev = 0;
        m_shadow = '0; m_active = '0;
        exp_q.delete();
        exp_q.push_back({24'h000000, 1'b0});
    endtask

    // Apply the rules for one input pixel and queue its expected output
    task automatic model_step(input int h, input int v, input logic [23:0] cam);
        bit   fs, hit;
        exp_t e;
        fs    = m_prev_zero;
        m_acc = 0;
        if (!en) begin
            m_armed   = 0;
            m_drawing = 0;
        end else begin
            if (m_armed && fs) m_drawing = 1;
            m_armed = 1;
        end
        if (fs && m_full) begin
            m_active = m_shadow;
            m_full   = 0;
        end else if (bval && !m_full) begin
            m_shadow = bdat;
            m_full   = 1;
            m_acc    = 1;
        end
        if (fs) m_done_sent = 0;
        hit = m_drawing && h == LAST_H && v == LAST_V && !m_done_sent;
        if (hit) m_done_sent = 1;
        e.rgb  = ref_color(h, v, cam, m_drawing, m_active);
        e.done = m_hit_prev;
        exp_q.push_back(e);
        m_hit_prev  = hit;
        m_prev_zero = (h == 0 && v == 0);
    endtask

    task automatic pix(input int h, input int v);
        logic [23:0] cam;
        exp_t        e;
        cam           = 24'($urandom);
        i_H_Counter   = 13'(h);
        i_V_Counter   = 13'(v);
        {i_Red, i_Green, i_Blue} = cam;
        i_enable      = en;
        i_board_valid = bval;
        i_board       = bdat;
        model_step(h, v, cam);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check1($sformatf("rgb(h=%0d,v=%0d)", h, v), 32'({o_Red, o_Green, o_Blue}), 32'(e.rgb));
        check1($sformatf("frame_done(h=%0d,v=%0d)", h, v), 32'(o_frame_done), 32'(e.done));
        check1($sformatf("ready(h=%0d,v=%0d)", h, v), 32'(o_board_ready), 32'(!m_full));
        if (m_acc) bval = 0;
    endtask

    task automatic rand_pix(input int n);
        for (int i = 0; i < n; i++) begin
            pix($urandom_range(140, 730), $urandom_range(30, 610));
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        en = 0; bval = 0;
        i_enable = 1'b0; i_board_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        check1("reset_rgb", 32'({o_Red, o_Green, o_Blue}), 32'h0);
        check1("reset_frame_done", 32'(o_frame_done), 32'h0);
        check1("reset_ready", 32'(o_board_ready), 32'h1);
    endtask

    initial begin
        i_rst = 1'b1; i_enable = 1'b0;
        {i_Red, i_Green, i_Blue} = '0;
        i_H_Counter = '0; i_V_Counter = '0;
        i_board = '0; i_board_valid = 1'b0;
        bdat = '0;

        // Reset, then pass-through while disabled
        do_reset();
        rand_pix(6);

        // All tiles = 1: red interior, white edges, camera outside
        bdat = {16{4'h1}}; bval = 1;
        pix(10, 10);
        en = 1;
        pix(20, 10);
        pix(300, 200);          // armed but no frame start yet: pass-through
        pix(0, 0);
        pix(300, 200); pix(155, 200); pix(100, 200);
        pix(156, 200); pix(157, 200); pix(292, 200); pix(293, 200); pix(294, 200);
        pix(295, 200); pix(714, 200); pix(715, 200); pix(300, 46); pix(300, 47);
        pix(300, 48); pix(300, 589); pix(300, 590);
        rand_pix(30);

        // Second board stalls behind the first until the first is committed
        bdat = 64'h0123_4567_89AB_CDEF; bval = 1;
        pix(400, 300);
        bdat = 64'hFEDC_BA98_7654_3210; bval = 1;
        pix(400, 300); pix(500, 400); pix(600, 500);
        pix(0, 0);
        pix(1, 0);              // commit of first board
        pix(2, 0);              // second board accepted
        rand_pix(25);
        pix(0, 0);
        rand_pix(25);

        // Only tile (3,3) = 2; single completion pulse per frame
        bdat = 64'h0000_0000_0000_0002; bval = 1;
        pix(5, 5);
        pix(0, 0);
        pix(650, 550); pix(200, 100); pix(600, 400);
        rand_pix(20);
        pix(LAST_H, LAST_V);
        pix(10, 600); pix(11, 600); pix(12, 600);
        pix(LAST_H, LAST_V);
        pix(10, 600); pix(11, 600); pix(12, 600);

        // Disable mid-frame, then re-enable and resume at the next frame start
        bdat = 64'h1234_5678_9ABC_DEF1; bval = 1;
        pix(0, 0);
        pix(1, 0);
        rand_pix(10);
        pix(400, 299);
        en = 0;
        pix(400, 300); pix(401, 300);
        rand_pix(8);
        pix(LAST_H, LAST_V);
        pix(10, 600); pix(11, 600); pix(12, 600);
        en = 1;
        rand_pix(6);
        pix(LAST_H, LAST_V);
        pix(10, 600); pix(11, 600);
        pix(0, 0);
        rand_pix(15);
        pix(LAST_H, LAST_V);
        pix(10, 600); pix(11, 600); pix(12, 600);

        // Accept coincident with frame start while the shadow is empty
        pix(0, 0);
        bdat = {16{4'h3}}; bval = 1;
        pix(1, 0);
        rand_pix(12);
        pix(0, 0);
        rand_pix(12);

        // Reset mid-frame with a pending board: shadow discarded
        bdat = {16{4'h5}}; bval = 1;
        pix(300, 300);
        rand_pix(3);
        do_reset();
        en = 1;
        pix(155, 200); pix(300, 200);
        pix(0, 0);
        pix(155, 200); pix(300, 200);
        rand_pix(15);
        pix(LAST_H, LAST_V);
        pix(10, 600); pix(11, 600); pix(12, 600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
